// File: rtl/frame_fifo_sync.sv
// Single-clock frame assembler and frame FIFO: words are staged per channel slot,
// committed as one NUM_CH-word frame on last_word, and buffered DEPTH deep (show-ahead).

module frame_fifo_slot #(
    parameter int WORD_W = 16
) (
    input  logic              sample_clk,
    input  logic              reset_n,
    input  logic              hit,
    input  logic              clr,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] merged
);
    logic [WORD_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr)
            slot_d = '0;
        else if (hit)
            slot_d = data_in;
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    // The closing word is merged in without passing through the staging flop.
    assign merged = hit ? data_in : slot_q;
endmodule

module frame_fifo_sync #(
    parameter int WORD_W = 16,
    parameter int NUM_CH = 8,
    parameter int DEPTH  = 16,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                     sample_clk,
    input  logic                     reset_n,
    input  logic [WORD_W-1:0]        data_in,
    input  logic                     done,
    input  logic [SEL_W-1:0]         atmchsel,
    input  logic                     last_word,
    input  logic [CNT_W-1:0]         threshold,
    input  logic                     ovf_mode,
    input  logic                     flush,
    input  logic                     frame_pop,
    input  logic                     clear_flags,
    output logic [NUM_CH*WORD_W-1:0] frame_data_out,
    output logic                     fifo_ready,
    output logic [CNT_W-1:0]         frame_count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int FRAME_W = NUM_CH * WORD_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [NUM_CH-1:0][WORD_W-1:0] frame_merged;
    logic [NUM_CH-1:0]             slot_hit;
    logic                          commit;
    logic                          stage_clr;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_en;

    logic [FRAME_W-1:0] mem_q [DEPTH];

    assign commit    = done && last_word;
    assign stage_clr = flush || commit;

    // Out-of-range channel selects match no slot, so the word is silently dropped.
    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_slot
            assign slot_hit[k] = done && (atmchsel == SEL_W'(k));
            frame_fifo_slot #(.WORD_W(WORD_W)) u_slot (
                .sample_clk (sample_clk),
                .reset_n    (reset_n),
                .hit        (slot_hit[k]),
                .clr        (stage_clr),
                .data_in    (data_in),
                .merged     (frame_merged[k])
            );
        end
    endgenerate

    always_comb begin
        logic full;
        logic do_pop;
        logic cnt_inc;
        logic rd_inc;
        logic ovf_set;
        logic udf_set;

        full    = (count_q == DEPTH_C);
        do_pop  = frame_pop && (count_q != '0);
        wr_en   = 1'b0;
        cnt_inc = 1'b0;
        rd_inc  = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            udf_set = frame_pop && (count_q == '0);
            // A pop in the same cycle frees a slot, so a full FIFO still accepts.
            if (commit) begin
                if (!full || do_pop) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                end else if (ovf_mode) begin
                    wr_en   = 1'b1;
                    rd_inc  = 1'b1;
                    ovf_set = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            if (do_pop)
                rd_inc = 1'b1;
            if (wr_en)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_inc)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(do_pop);
        end

        ovf_d = ovf_q;
        if (ovf_set)
            ovf_d = 1'b1;
        else if (clear_flags)
            ovf_d = 1'b0;

        udf_d = udf_q;
        if (udf_set)
            udf_d = 1'b1;
        else if (clear_flags)
            udf_d = 1'b0;
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Frame storage needs no reset: an entry is only visible while count_q covers it.
    always_ff @(posedge sample_clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= frame_merged;
    end

    assign frame_data_out = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign fifo_ready     = count_q >= ((threshold == '0) ? CNT_W'(1) : threshold);
    assign frame_count    = count_q;
    assign overflow       = ovf_q;
    assign underflow      = udf_q;
endmodule

// File: tb/tb_frame_fifo_sync.sv
// Directed bench for frame_fifo_sync: one task per scenario, inline checks, hand-derived expectations.

module tb_frame_fifo_sync;
    localparam int WORD_W = 16;
    localparam int NUM_CH = 8;
    localparam int DEPTH  = 16;
    localparam int SEL_W  = 3;
    localparam int CNT_W  = 5;

    logic                     sample_clk = 1'b0;
    logic                     reset_n;
    logic [WORD_W-1:0]        data_in;
    logic                     done;
    logic [SEL_W-1:0]         atmchsel;
    logic                     last_word;
    logic [CNT_W-1:0]         threshold;
    logic                     ovf_mode;
    logic                     flush;
    logic                     frame_pop;
    logic                     clear_flags;
    logic [NUM_CH*WORD_W-1:0] frame_data_out;
    logic                     fifo_ready;
    logic [CNT_W-1:0]         frame_count;
    logic                     overflow;
    logic                     underflow;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    frame_fifo_sync #(.WORD_W(WORD_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .sample_clk     (sample_clk),
        .reset_n        (reset_n),
        .data_in        (data_in),
        .done           (done),
        .atmchsel       (atmchsel),
        .last_word      (last_word),
        .threshold      (threshold),
        .ovf_mode       (ovf_mode),
        .flush          (flush),
        .frame_pop      (frame_pop),
        .clear_flags    (clear_flags),
        .frame_data_out (frame_data_out),
        .fifo_ready     (fifo_ready),
        .frame_count    (frame_count),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 sample_clk = ~sample_clk;

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic idle_in();
        data_in     = '0;
        done        = 1'b0;
        atmchsel    = '0;
        last_word   = 1'b0;
        flush       = 1'b0;
        frame_pop   = 1'b0;
        clear_flags = 1'b0;
    endtask

    task automatic commit_single(input logic [WORD_W-1:0] d);
        done = 1'b1; data_in = d; atmchsel = '0; last_word = 1'b1;
        tick();
        idle_in();
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_pop = 1'b1;
            tick();
        end
        frame_pop = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1; clear_flags = 1'b1;
        tick();
        idle_in();
    endtask

    task automatic test_reset();
        commit_single(16'h1111);
        done = 1'b1; data_in = 16'h2222; atmchsel = 3'd3;
        tick();
        idle_in();
        #3 reset_n = 1'b0;
        #1;
        chk_cnt++; if (fifo_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", fifo_ready); else pass_cnt++;
        chk_cnt++; if (frame_count !== 5'd0) $display("FAIL reset_count got %0d want 0", frame_count); else pass_cnt++;
        chk_cnt++; if (frame_data_out !== 128'd0) $display("FAIL reset_data got %h want 0", frame_data_out); else pass_cnt++;
        chk_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_flags got %b want 00", {overflow, underflow}); else pass_cnt++;
        tick();
        reset_n = 1'b1;
        tick();
        // Staging must have been discarded: the half-built frame's slot 3 is gone.
        commit_single(16'h0042);
        chk_cnt++; if (frame_data_out !== 128'h42) $display("FAIL reset_stage got %h want %h", frame_data_out, 128'h42); else pass_cnt++;
        pop_n(1);
    endtask

    task automatic test_back_to_back();
        logic [NUM_CH*WORD_W-1:0] exp;
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 8; w++) begin
                done = 1'b1; data_in = 16'((f << 8) | w); atmchsel = 3'(w); last_word = (w == 7);
                tick();
            end
        end
        idle_in();
        chk_cnt++; if (frame_count !== 5'd4) $display("FAIL b2b_count got %0d want 4", frame_count); else pass_cnt++;
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 8; w++) exp[w*WORD_W +: WORD_W] = 16'((f << 8) | w);
            chk_cnt++; if (frame_data_out !== exp) $display("FAIL b2b_frame%0d got %h want %h", f, frame_data_out, exp); else pass_cnt++;
            pop_n(1);
        end
        chk_cnt++; if (frame_count !== 5'd0) $display("FAIL b2b_drain got %0d want 0", frame_count); else pass_cnt++;
        chk_cnt++; if (frame_data_out !== 128'd0) $display("FAIL b2b_empty_data got %h want 0", frame_data_out); else pass_cnt++;
    endtask

    task automatic test_partial();
        logic [NUM_CH*WORD_W-1:0] exp;
        done = 1'b1; data_in = 16'h55AA; atmchsel = 3'd0; last_word = 1'b0;
        tick();
        atmchsel = 3'd1; last_word = 1'b1;
        tick();
        idle_in();
        exp = '0;
        exp[31:0] = 32'h55AA_55AA;
        chk_cnt++; if (frame_data_out !== exp) $display("FAIL partial_frame got %h want %h", frame_data_out, exp); else pass_cnt++;
        pop_n(1);
    endtask

    task automatic test_threshold();
        for (int i = 0; i < 5; i++) commit_single(16'(i));
        threshold = 5'd5; #1;
        chk_cnt++; if (fifo_ready !== 1'b1) $display("FAIL thr5_ready got %b want 1", fifo_ready); else pass_cnt++;
        threshold = 5'd6; #1;
        chk_cnt++; if (fifo_ready !== 1'b0) $display("FAIL thr6_ready got %b want 0", fifo_ready); else pass_cnt++;
        pop_n(4);
        threshold = 5'd0; #1;
        chk_cnt++; if (fifo_ready !== 1'b1) $display("FAIL thr0_cnt1_ready got %b want 1", fifo_ready); else pass_cnt++;
        pop_n(1);
        chk_cnt++; if (fifo_ready !== 1'b0) $display("FAIL thr0_cnt0_ready got %b want 0", fifo_ready); else pass_cnt++;
        threshold = 5'd1;
    endtask

    task automatic test_overflow(input logic mode);
        do_flush();
        ovf_mode = mode;
        for (int i = 0; i < 17; i++) commit_single(16'(i));
        chk_cnt++; if (frame_count !== 5'd16) $display("FAIL ovf%0b_count got %0d want 16", mode, frame_count); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf%0b_flag got %b want 1", mode, overflow); else pass_cnt++;
        chk_cnt++; if (frame_data_out !== (mode ? 128'd1 : 128'd0)) $display("FAIL ovf%0b_head got %h want %h", mode, frame_data_out, mode ? 128'd1 : 128'd0); else pass_cnt++;
        pop_n(15);
        chk_cnt++; if (frame_data_out !== (mode ? 128'd16 : 128'd15)) $display("FAIL ovf%0b_tail got %h want %h", mode, frame_data_out, mode ? 128'd16 : 128'd15); else pass_cnt++;
        ovf_mode = 1'b0;
    endtask

    task automatic test_corners();
        logic [NUM_CH*WORD_W-1:0] exp;
        do_flush();
        pop_n(1);
        chk_cnt++; if (underflow !== 1'b1) $display("FAIL empty_pop_udf got %b want 1", underflow); else pass_cnt++;
        chk_cnt++; if (frame_count !== 5'd0) $display("FAIL empty_pop_count got %0d want 0", frame_count); else pass_cnt++;
        for (int i = 0; i < 16; i++) commit_single(16'(i));
        clear_flags = 1'b1; tick(); idle_in();
        // Commit and pop together while full: the pop makes room, nothing is lost.
        done = 1'b1; data_in = 16'h0099; last_word = 1'b1; frame_pop = 1'b1;
        tick();
        idle_in();
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL full_cpop_ovf got %b want 0", overflow); else pass_cnt++;
        chk_cnt++; if (frame_count !== 5'd16) $display("FAIL full_cpop_count got %0d want 16", frame_count); else pass_cnt++;
        chk_cnt++; if (frame_data_out !== 128'd1) $display("FAIL full_cpop_head got %h want 1", frame_data_out); else pass_cnt++;
        commit_single(16'h00AB);
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL full_drop_ovf got %b want 1", overflow); else pass_cnt++;
        done = 1'b1; data_in = 16'hBEEF; atmchsel = 3'd0;
        tick();
        done = 1'b1; data_in = 16'h7777; atmchsel = 3'd2; last_word = 1'b1; flush = 1'b1;
        tick();
        idle_in();
        chk_cnt++; if (frame_count !== 5'd0) $display("FAIL flush_count got %0d want 0", frame_count); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL flush_keeps_ovf got %b want 1", overflow); else pass_cnt++;
        done = 1'b1; data_in = 16'h1234; atmchsel = 3'd1; last_word = 1'b1;
        tick();
        idle_in();
        exp = '0;
        exp[31:16] = 16'h1234;
        chk_cnt++; if (frame_data_out !== exp) $display("FAIL flush_stage_clr got %h want %h", frame_data_out, exp); else pass_cnt++;
        frame_pop = 1'b1; clear_flags = 1'b1;
        tick();
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL clr_ovf got %b want 0", overflow); else pass_cnt++;
        tick();
        idle_in();
        chk_cnt++; if (underflow !== 1'b1) $display("FAIL clr_vs_set_udf got %b want 1", underflow); else pass_cnt++;
        clear_flags = 1'b1; tick(); idle_in();
        chk_cnt++; if ({overflow, underflow} !== 2'b00) $display("FAIL clr_flags got %b want 00", {overflow, underflow}); else pass_cnt++;
    endtask

    initial begin
        idle_in();
        reset_n   = 1'b0;
        threshold = 5'd1;
        ovf_mode  = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_back_to_back();
        test_partial();
        test_threshold();
        test_overflow(1'b0);
        test_overflow(1'b1);
        test_corners();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
